// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if
//   Bus between a 1:10 deserializer (master) and one TMDS channel decoder (slave).
//   tmds_raw         deserializer word, bit 0 = first bit received
//   locked           symbol alignment achieved
//   bit_offset       current alignment offset, 0..9
//   control_valid    symbol is a control token
//   control_data     decoded {c1,c0}
//   video_data       8b video decode
//   terc4_valid      symbol is a TERC4 code
//   terc4_data       decoded TERC4 nibble
//   guard            symbol is the video guard band for this channel
//   lock_loss_count  saturating count of lock drops
interface tmds_channel_decoder_if;
  logic [9:0] tmds_raw;
  logic       locked;
  logic [3:0] bit_offset;
  logic       control_valid;
  logic [1:0] control_data;
  logic [7:0] video_data;
  logic       terc4_valid;
  logic [3:0] terc4_data;
  logic       guard;
  logic [7:0] lock_loss_count;

  modport master (
    output tmds_raw,
    input  locked, bit_offset, control_valid, control_data, video_data,
           terc4_valid, terc4_data, guard, lock_loss_count
  );

  modport slave (
    input  tmds_raw,
    output locked, bit_offset, control_valid, control_data, video_data,
           terc4_valid, terc4_data, guard, lock_loss_count
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   Sink-side decoder for one TMDS channel. Aligns the deserializer word by
//   locking onto control tokens, then decodes each aligned symbol into video,
//   control, TERC4 and guard-band fields.
//   Optional feature: `define TMDS_DECODER_LOSS_COUNT_EN builds the saturating
//   lock-loss counter; otherwise lock_loss_count is tied to zero.
// Ports
//   clk_pixel   pixel clock
//   reset       synchronous active-high reset
//   bus         tmds_channel_decoder_if.slave (tmds_raw in, decoded fields out)
//
// state     | meaning
// ST_SEARCH | hunting for LOCK_COUNT consecutive control tokens at bit_offset
// ST_LOCKED | aligned; drops back to search after LOSS_TIMEOUT cycles w/o token
module tmds_channel_decoder #(
  parameter int CN             = 0,
  parameter int LOCK_COUNT     = 16,
  parameter int SEARCH_TIMEOUT = 64,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input logic                  clk_pixel,
  input logic                  reset,
  tmds_channel_decoder_if.slave bus
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMR_W  = $clog2(SEARCH_TIMEOUT);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] GUARD_SYM = (CN == 1) ? 10'b0100110011 : 10'b1011001100;

  typedef enum logic [0:0] {ST_SEARCH, ST_LOCKED} state_t;

  state_t            state_q;
  logic [9:0]        prev_q;
  logic [9:0]        s1_q;
  logic [9:0]        s1_d;
  logic [3:0]        bit_offset_q;
  logic              locked_q;
  logic              ignore_q;
  logic [RUN_W-1:0]  run_q;
  logic [TMR_W-1:0]  timer_q;
  logic [LOSS_W-1:0] loss_q;

  logic       ctrl_v_q, t4_v_q, guard_q;
  logic [1:0] ctrl_d_q;
  logic [7:0] vid_q;
  logic [3:0] t4_d_q;

  logic       ctrl_v_d, t4_v_d, guard_d;
  logic [1:0] ctrl_d_d;
  logic [7:0] vid_d;
  logic [3:0] t4_d_d;
  logic [7:0] dinv;

  logic [19:0] window;
  assign window = {bus.tmds_raw, prev_q};

  always_comb begin
    s1_d = window[9:0];
    for (int i = 1; i < 10; i++) begin
      if (bit_offset_q == 4'(i)) s1_d = window[i +: 10];
    end
  end

  always_comb begin
    ctrl_v_d = 1'b1;
    ctrl_d_d = 2'b00;
    case (s1_q)
      10'b1101010100: ctrl_d_d = 2'b00;
      10'b0010101011: ctrl_d_d = 2'b01;
      10'b0101010100: ctrl_d_d = 2'b10;
      10'b1010101011: ctrl_d_d = 2'b11;
      default:        ctrl_v_d = 1'b0;
    endcase

    t4_v_d = 1'b1;
    t4_d_d = 4'h0;
    case (s1_q)
      10'b1010011100: t4_d_d = 4'h0;
      10'b1001100011: t4_d_d = 4'h1;
      10'b1011100100: t4_d_d = 4'h2;
      10'b1011100010: t4_d_d = 4'h3;
      10'b0101110001: t4_d_d = 4'h4;
      10'b0100011110: t4_d_d = 4'h5;
      10'b0110001110: t4_d_d = 4'h6;
      10'b0100111100: t4_d_d = 4'h7;
      10'b1011001100: t4_d_d = 4'h8;
      10'b0100111001: t4_d_d = 4'h9;
      10'b0110011100: t4_d_d = 4'hA;
      10'b1011000110: t4_d_d = 4'hB;
      10'b1010001110: t4_d_d = 4'hC;
      10'b1001110001: t4_d_d = 4'hD;
      10'b0101100011: t4_d_d = 4'hE;
      10'b1011000011: t4_d_d = 4'hF;
      default:        t4_v_d = 1'b0;
    endcase
    if (ctrl_v_d) begin
      t4_v_d = 1'b0;
      t4_d_d = 4'h0;
    end

    // bit 9 flags inverted payload, bit 8 selects XOR vs XNOR chaining
    dinv     = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
    vid_d    = 8'h00;
    vid_d[0] = dinv[0];
    for (int i = 1; i < 8; i++) begin
      vid_d[i] = s1_q[8] ? (dinv[i] ^ dinv[i-1]) : ~(dinv[i] ^ dinv[i-1]);
    end

    guard_d = (s1_q == GUARD_SYM);
  end

`ifdef TMDS_DECODER_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;
  assign bus.lock_loss_count = loss_cnt_q;
`else
  assign bus.lock_loss_count = 8'd0;
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q      <= ST_SEARCH;
      prev_q       <= '0;
      s1_q         <= '0;
      bit_offset_q <= '0;
      locked_q     <= 1'b0;
      ignore_q     <= 1'b0;
      run_q        <= '0;
      timer_q      <= '0;
      loss_q       <= '0;
      ctrl_v_q     <= 1'b0;
      ctrl_d_q     <= '0;
      vid_q        <= '0;
      t4_v_q       <= 1'b0;
      t4_d_q       <= '0;
      guard_q      <= 1'b0;
`ifdef TMDS_DECODER_LOSS_COUNT_EN
      loss_cnt_q   <= '0;
`endif
    end else begin
      prev_q   <= bus.tmds_raw;
      s1_q     <= s1_d;
      ctrl_v_q <= ctrl_v_d;
      ctrl_d_q <= ctrl_d_d;
      vid_q    <= vid_d;
      t4_v_q   <= t4_v_d;
      t4_d_q   <= t4_d_d;
      guard_q  <= guard_d;

      case (state_q)
        ST_SEARCH: begin
          if (ctrl_v_d && !ignore_q && run_q == RUN_LAST) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
            run_q    <= '0;
            timer_q  <= '0;
            loss_q   <= '0;
            ignore_q <= 1'b0;
          end else if (timer_q == TMR_LAST) begin
            bit_offset_q <= (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
            run_q        <= '0;
            timer_q      <= '0;
            // stage1 word already in flight was taken at the old offset
            ignore_q     <= 1'b1;
          end else begin
            timer_q  <= timer_q + 1'b1;
            ignore_q <= 1'b0;
            if (!ignore_q) run_q <= ctrl_v_d ? run_q + 1'b1 : '0;
          end
        end
        ST_LOCKED: begin
          if (ctrl_v_d) begin
            loss_q <= '0;
          end else if (loss_q == LOSS_LAST) begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
            loss_q   <= '0;
            run_q    <= '0;
            timer_q  <= '0;
`ifdef TMDS_DECODER_LOSS_COUNT_EN
            if (loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
`endif
          end else begin
            loss_q <= loss_q + 1'b1;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign bus.locked        = locked_q;
  assign bus.bit_offset    = bit_offset_q;
  assign bus.control_valid = ctrl_v_q;
  assign bus.control_data  = ctrl_d_q;
  assign bus.video_data    = vid_q;
  assign bus.terc4_valid   = t4_v_q;
  assign bus.terc4_data    = t4_d_q;
  assign bus.guard         = guard_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder
//   Bench for tmds_channel_decoder (CN=1, default timeouts). Stimulus tasks
//   run in sequence; decoded fields are checked against a scoreboard queue.
module tb_tmds_channel_decoder;
  localparam int LOCK_COUNT     = 16;
  localparam int SEARCH_TIMEOUT = 64;
  localparam int LOSS_TIMEOUT   = 4096;
  localparam int LAT            = 3;  // prev, stage1, stage2 registers
  localparam logic [9:0] TOK0   = 10'b1101010100;
  localparam logic [9:0] GUARD1 = 10'b0100110011;
  localparam logic [9:0] T4TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
`ifdef TMDS_DECODER_LOSS_COUNT_EN
  localparam logic [7:0] LOSS_CNT_EXP = 8'd1;
`else
  localparam logic [7:0] LOSS_CNT_EXP = 8'd0;
`endif

  typedef struct packed {
    logic       cv;
    logic [1:0] cd;
    logic [7:0] vd;
    logic       tv;
    logic [3:0] td;
    logic       g;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  tmds_channel_decoder_if bus ();

  tmds_channel_decoder #(
    .CN(1), .LOCK_COUNT(LOCK_COUNT),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT), .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .clk_pixel(clk),
    .reset(rst),
    .bus(bus)
  );

  function automatic exp_t model(input logic [9:0] s);
    exp_t e;
    logic [7:0] d;
    e = '0;
    if (s == 10'b1101010100) begin e.cv = 1; e.cd = 2'd0; end
    if (s == 10'b0010101011) begin e.cv = 1; e.cd = 2'd1; end
    if (s == 10'b0101010100) begin e.cv = 1; e.cd = 2'd2; end
    if (s == 10'b1010101011) begin e.cv = 1; e.cd = 2'd3; end
    for (int k = 0; k < 16; k++) begin
      if (!e.cv && s == T4TAB[k]) begin e.tv = 1; e.td = 4'(k); end
    end
    d = s[7:0];
    if (s[9]) d = ~d;
    e.vd[0] = d[0];
    for (int k = 1; k < 8; k++) e.vd[k] = s[8] ? (d[k] ^ d[k-1]) : !(d[k] ^ d[k-1]);
    e.g = (s == GUARD1);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tmds_raw = 10'h3FF;
    repeat (3) tick();
    n_checks++;
    if ({bus.locked, bus.bit_offset, bus.control_valid, bus.control_data, bus.video_data,
         bus.terc4_valid, bus.terc4_data, bus.guard, bus.lock_loss_count} !== '0)
      $display("FAIL reset_state: locked=%b off=%0d cv=%b cd=%b vd=%h tv=%b td=%h g=%b llc=%0d, all zero required",
               bus.locked, bus.bit_offset, bus.control_valid, bus.control_data, bus.video_data,
               bus.terc4_valid, bus.terc4_data, bus.guard, bus.lock_loss_count);
    else n_pass++;
  endtask

  task automatic test_lock_aligned();
    int lock_c = 0;
    rst = 1'b1;
    bus.tmds_raw = TOK0;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (bus.locked && lock_c == 0) lock_c = c;
    end
    n_checks++;
    if (lock_c != LOCK_COUNT + 2)
      $display("FAIL lock_latency: locked after %0d cycles, required %0d", lock_c, LOCK_COUNT + 2);
    else n_pass++;
    n_checks++;
    if (bus.bit_offset !== 4'd0 || bus.control_valid !== 1'b1 || bus.control_data !== 2'b00)
      $display("FAIL lock_aligned_fields: off=%0d cv=%b cd=%b, required 0/1/00",
               bus.bit_offset, bus.control_valid, bus.control_data);
    else n_pass++;
  endtask

  task automatic test_decode_scoreboard();
    logic [9:0] syms [12];
    int n = 12;
    exp_t e;
    syms[0] = 10'b0100000000; syms[1] = 10'b1011111111;
    syms[2] = 10'b1010011100; syms[3] = 10'b0100110011;
    syms[4] = 10'b1011001100; syms[5] = 10'b0101010100;
    syms[6] = 10'b1010101011; syms[7] = 10'b0101100011;
    for (int k = 8; k < 12; k++) syms[k] = 10'($urandom_range(0, 1023));
    for (int k = 0; k < n + LAT; k++) begin
      if (k >= LAT) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({bus.control_valid, bus.control_data, bus.video_data, bus.terc4_valid,
             bus.terc4_data, bus.guard} !== e)
          $display("FAIL decode_sym%0d (%b): got cv=%b cd=%b vd=%h tv=%b td=%h g=%b, required cv=%b cd=%b vd=%h tv=%b td=%h g=%b",
                   k - LAT, syms[k - LAT], bus.control_valid, bus.control_data, bus.video_data,
                   bus.terc4_valid, bus.terc4_data, bus.guard, e.cv, e.cd, e.vd, e.tv, e.td, e.g);
        else n_pass++;
      end
      if (k < n) begin
        bus.tmds_raw = syms[k];
        sb_q.push_back(model(syms[k]));
      end else begin
        bus.tmds_raw = TOK0;
      end
      tick();
    end
    n_checks++;
    if (bus.locked !== 1'b1)
      $display("FAIL decode_keeps_lock: locked=%b, required 1", bus.locked);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    int drop_c = 0;
    bus.tmds_raw = 10'b0100000000;
    for (int c = 1; c <= LOSS_TIMEOUT + 10; c++) begin
      tick();
      if (!bus.locked && drop_c == 0) drop_c = c;
    end
    n_checks++;
    if (drop_c != LOSS_TIMEOUT + 2)
      $display("FAIL loss_latency: lock dropped after %0d cycles, required %0d", drop_c, LOSS_TIMEOUT + 2);
    else n_pass++;
    n_checks++;
    if (bus.lock_loss_count !== LOSS_CNT_EXP)
      $display("FAIL loss_count: got %0d, required %0d", bus.lock_loss_count, LOSS_CNT_EXP);
    else n_pass++;
  endtask

  task automatic test_reset_mid_lock();
    int lock_c = 0;
    bus.tmds_raw = TOK0;
    for (int c = 1; c <= 1000 && lock_c == 0; c++) begin
      tick();
      if (bus.locked) lock_c = c;
    end
    n_checks++;
    if (lock_c == 0 || bus.bit_offset !== 4'd0)
      $display("FAIL relock: locked=%b off=%0d, required 1/0 within 1000 cycles", bus.locked, bus.bit_offset);
    else n_pass++;
    n_checks++;
    if (bus.lock_loss_count !== LOSS_CNT_EXP)
      $display("FAIL loss_count_held: got %0d, required %0d", bus.lock_loss_count, LOSS_CNT_EXP);
    else n_pass++;
    bus.tmds_raw = 10'b1011111111;
    repeat (LAT) tick();
    n_checks++;
    if (bus.video_data !== 8'hFE || bus.locked !== 1'b1)
      $display("FAIL pre_reset_video: vd=%h locked=%b, required fe/1", bus.video_data, bus.locked);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.locked, bus.bit_offset, bus.control_valid, bus.control_data, bus.video_data,
         bus.terc4_valid, bus.terc4_data, bus.guard, bus.lock_loss_count} !== '0)
      $display("FAIL reset_mid_lock: locked=%b off=%0d cv=%b cd=%b vd=%h tv=%b td=%h g=%b llc=%0d, all zero required",
               bus.locked, bus.bit_offset, bus.control_valid, bus.control_data, bus.video_data,
               bus.terc4_valid, bus.terc4_data, bus.guard, bus.lock_loss_count);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_search_slip();
    logic [9:0] rot;
    int lock_c = 0;
    // window[i+3] reproduces TOK0[i]: lock expected at offset 3
    for (int j = 0; j < 10; j++) rot[j] = TOK0[(j + 7) % 10];
    rst = 1'b1;
    bus.tmds_raw = rot;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      tick();
      if (c == SEARCH_TIMEOUT - 1) begin
        n_checks++;
        if (bus.bit_offset !== 4'd0)
          $display("FAIL slip_early: off=%0d at cycle %0d, required 0", bus.bit_offset, c);
        else n_pass++;
      end
      if (c == SEARCH_TIMEOUT || c == 2 * SEARCH_TIMEOUT) begin
        n_checks++;
        if (bus.bit_offset !== 4'(c / SEARCH_TIMEOUT))
          $display("FAIL slip_step: off=%0d at cycle %0d, required %0d", bus.bit_offset, c, c / SEARCH_TIMEOUT);
        else n_pass++;
      end
      if (bus.locked && lock_c == 0) lock_c = c;
    end
    n_checks++;
    if (lock_c != 3 * SEARCH_TIMEOUT + LOCK_COUNT + 1)
      $display("FAIL slip_lock_cycle: locked at %0d, required %0d", lock_c, 3 * SEARCH_TIMEOUT + LOCK_COUNT + 1);
    else n_pass++;
    n_checks++;
    if (bus.bit_offset !== 4'd3 || bus.control_valid !== 1'b1 || bus.control_data !== 2'b00)
      $display("FAIL slip_lock_fields: off=%0d cv=%b cd=%b, required 3/1/00",
               bus.bit_offset, bus.control_valid, bus.control_data);
    else n_pass++;
  endtask

  initial begin
    bus.tmds_raw = '0;
    test_reset();
    test_lock_aligned();
    test_decode_scoreboard();
    test_lock_loss();
    test_reset_mid_lock();
    test_search_slip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
